// File: rtl/note_recorder.sv
// note_recorder
//   Record/playback engine for the piano note path. In REC it samples the
//   4-bit keyboard note code once per tick and run-length encodes it into a
//   small on-chip buffer of {note, duration} entries. In PLAY it regenerates
//   the same note stream plus a buzzer enable from that buffer.
//
// Handshake: commands are single-cycle pulses sampled on the rising edge.
//   Same-cycle priority is stop > rec_start > play_start. rec_start and
//   play_start act only in IDLE, and stop in IDLE does nothing.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_note_in     live note code (0 = silence, 1..15 = notes)
//   i_rec_start   pulse: begin recording
//   i_play_start  pulse: begin playback (ignored when buffer is empty)
//   i_stop        pulse: end the current operation
//   o_note_out    note code during playback, 0 otherwise
//   o_play_en     buzzer enable, high only in PLAY
//   o_recording   high in REC
//   o_playing     high in PLAY
//   o_count       number of valid buffer entries
//   o_full        high when o_count == DEPTH
//   o_state       current FSM state, for debug visibility
module note_recorder #(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_MS = 10,
    parameter int DEPTH   = 64,
    parameter int DUR_W   = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [3:0]               i_note_in,
    input  logic                     i_rec_start,
    input  logic                     i_play_start,
    input  logic                     i_stop,
    output logic [3:0]               o_note_out,
    output logic                     o_play_en,
    output logic                     o_recording,
    output logic                     o_playing,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic [1:0]               o_state
);

    localparam int TICK_CYC = CLK_HZ / 1000 * TICK_MS;
    localparam int TCW      = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = AW + 1;
    localparam int EW       = 4 + DUR_W;

    localparam logic [TCW-1:0]   TICK_LAST = TCW'(TICK_CYC - 1);
    localparam logic [DUR_W-1:0] DUR_MAX   = '1;
    localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);
    localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REC  = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    state_t             r_state;
    logic [TCW-1:0]     r_tick_cnt;
    logic [3:0]         r_cur_note;
    logic [DUR_W-1:0]   r_dur;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      r_idx;
    logic [DUR_W-1:0]   r_remaining;
    logic [3:0]         r_note_out;
    logic               r_play_en;
    logic               r_recording;
    logic               r_playing;
    logic               r_full;
    logic [EW-1:0]      r_mem [DEPTH];

    logic               w_tick;
    logic               w_enter_rec;
    logic               w_enter_play;
    logic               w_extend;
    logic               w_wr_en;
    logic [AW-1:0]      w_wr_addr;
    logic [EW-1:0]      w_wr_data;
    logic [CW-1:0]      w_count_inc;
    logic [CW-1:0]      w_idx_next;
    logic [EW-1:0]      w_first_entry;
    logic [EW-1:0]      w_next_entry;

    // Command decode: stop blocks both starts in IDLE.
    assign w_enter_rec  = (r_state == S_IDLE) && !i_stop && i_rec_start;
    assign w_enter_play = (r_state == S_IDLE) && !i_stop && !i_rec_start &&
                          i_play_start && (r_count != '0);

    assign w_tick = (r_tick_cnt == TICK_LAST);

    // The current run grows while the note is unchanged and has headroom;
    // a saturated run is closed and a fresh run of the same note begins.
    assign w_extend = (i_note_in == r_cur_note) && (r_dur != DUR_MAX);

    // A run is written when it is closed by a tick or flushed by stop, but
    // never an empty run and never past the end of the buffer.
    assign w_wr_en   = (r_state == S_REC) && (r_dur != '0) && (r_count != DEPTH_C) &&
                       (i_stop || (w_tick && !w_extend));
    assign w_wr_addr = r_count[AW-1:0];
    assign w_wr_data = {r_cur_note, r_dur};
    assign w_count_inc = r_count + CNT_ONE;

    // Combinational reads of the register array keep playback latency at
    // zero cycles past the loading edge.
    assign w_idx_next    = r_idx + CNT_ONE;
    assign w_first_entry = r_mem[0];
    assign w_next_entry  = r_mem[w_idx_next[AW-1:0]];

    // Tick divider restarts on entry to REC or PLAY so the first tick lands
    // exactly one period after the start command edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_enter_rec || w_enter_play || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TCW'(1);
        end
    end

    // Buffer storage: no reset, contents only change during REC.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Main FSM with registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cur_note  <= '0;
            r_dur       <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_remaining <= '0;
            r_note_out  <= '0;
            r_play_en   <= 1'b0;
            r_recording <= 1'b0;
            r_playing   <= 1'b0;
            r_full      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_enter_rec) begin
                        r_state     <= S_REC;
                        r_recording <= 1'b1;
                        r_count     <= '0;
                        r_full      <= 1'b0;
                        r_cur_note  <= i_note_in;
                        r_dur       <= '0;
                    end else if (w_enter_play) begin
                        r_state     <= S_PLAY;
                        r_playing   <= 1'b1;
                        r_play_en   <= 1'b1;
                        r_idx       <= '0;
                        r_note_out  <= w_first_entry[EW-1:DUR_W];
                        r_remaining <= w_first_entry[DUR_W-1:0];
                    end
                end

                S_REC: begin
                    if (i_stop) begin
                        if (w_wr_en) begin
                            r_count <= w_count_inc;
                            r_full  <= (w_count_inc == DEPTH_C);
                        end
                        r_state     <= S_IDLE;
                        r_recording <= 1'b0;
                    end else if (w_tick) begin
                        if (w_extend) begin
                            r_dur <= r_dur + DUR_ONE;
                        end else begin
                            r_cur_note <= i_note_in;
                            r_dur      <= DUR_ONE;
                            if (w_wr_en) begin
                                r_count <= w_count_inc;
                                // Buffer just filled: the new run is dropped.
                                if (w_count_inc == DEPTH_C) begin
                                    r_full      <= 1'b1;
                                    r_state     <= S_IDLE;
                                    r_recording <= 1'b0;
                                end
                            end
                        end
                    end
                end

                S_PLAY: begin
                    if (i_stop) begin
                        r_state    <= S_IDLE;
                        r_note_out <= '0;
                        r_play_en  <= 1'b0;
                        r_playing  <= 1'b0;
                    end else if (w_tick) begin
                        if (r_remaining <= DUR_ONE) begin
                            if (w_idx_next == r_count) begin
                                r_state    <= S_IDLE;
                                r_note_out <= '0;
                                r_play_en  <= 1'b0;
                                r_playing  <= 1'b0;
                            end else begin
                                r_idx       <= w_idx_next;
                                r_note_out  <= w_next_entry[EW-1:DUR_W];
                                r_remaining <= w_next_entry[DUR_W-1:0];
                            end
                        end else begin
                            r_remaining <= r_remaining - DUR_ONE;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_note_out  = r_note_out;
    assign o_play_en   = r_play_en;
    assign o_recording = r_recording;
    assign o_playing   = r_playing;
    assign o_count     = r_count;
    assign o_full      = r_full;
    assign o_state     = r_state;

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder: 10 cycles per tick, 4-entry buffer, 4-bit durations.
// Recordings are described as one note value per tick; the reference model
// splits that stream into runs, chops runs at the maximum duration and keeps
// the first DEPTH pieces. Playback is then checked cycle by cycle, skipping
// the cycle on either side of each expected note change.
module tb_note_recorder;

  localparam int TP    = 10;
  localparam int DEPTH = 4;
  localparam int DMAX  = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] note_in;
  logic       rec_start;
  logic       play_start;
  logic       stop;
  logic [3:0] note_out;
  logic       play_en;
  logic       recording;
  logic       playing;
  logic [2:0] count;
  logic       full;
  logic [1:0] dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // stimulus: note held during each tick period
  logic [3:0] rec_seq[$];
  // scoreboard: expected buffer contents
  logic [3:0] exp_note[$];
  logic [3:0] exp_dur[$];
  int         model_chunks;
  int         model_full;

  always #5 clk = ~clk;

  note_recorder #(
    .CLK_HZ (1000),
    .TICK_MS(10),
    .DEPTH  (DEPTH),
    .DUR_W  (4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_note_in   (note_in),
    .i_rec_start (rec_start),
    .i_play_start(play_start),
    .i_stop      (stop),
    .o_note_out  (note_out),
    .o_play_en   (play_en),
    .o_recording (recording),
    .o_playing   (playing),
    .o_count     (count),
    .o_full      (full),
    .o_state     (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void build_model();
    int i;
    int j;
    int len;
    int d;
    exp_note.delete();
    exp_dur.delete();
    model_chunks = 0;
    i = 0;
    while (i < rec_seq.size()) begin
      j = i;
      while (j < rec_seq.size() && rec_seq[j] == rec_seq[i]) j++;
      len = j - i;
      while (len > 0) begin
        d = (len > DMAX) ? DMAX : len;
        if (exp_note.size() < DEPTH) begin
          exp_note.push_back(rec_seq[i]);
          exp_dur.push_back(4'(d));
        end
        model_chunks++;
        len -= d;
      end
      i = j;
    end
    model_full = (model_chunks >= DEPTH) ? 1 : 0;
  endfunction

  function automatic int play_total();
    int acc = 0;
    foreach (exp_dur[k]) acc += int'(exp_dur[k]) * TP;
    return acc;
  endfunction

  // Expected note_out t cycles after the play_start edge.
  function automatic int exp_at(input int t);
    int acc = 0;
    foreach (exp_dur[k]) begin
      acc += int'(exp_dur[k]) * TP;
      if (t < acc) return int'(exp_note[k]);
    end
    return 0;
  endfunction

  task automatic do_record(input string tag);
    build_model();
    @(negedge clk);
    note_in   = rec_seq[0];
    rec_start = 1'b1;
    @(negedge clk);
    rec_start = 1'b0;
    check({tag, "_rec_flag"}, 32'(recording), 1);
    check({tag, "_count_clr"}, 32'(count), 0);
    for (int k = 0; k < rec_seq.size(); k++) begin
      note_in = rec_seq[k];
      repeat (TP) @(negedge clk);
    end
    check({tag, "_auto_idle"}, 32'(recording), (model_chunks > DEPTH) ? 0 : 1);
    stop = 1'b1;
    @(negedge clk);
    stop    = 1'b0;
    note_in = 4'd0;
    check({tag, "_rec_done"}, 32'(recording), 0);
    check({tag, "_count"}, 32'(count), exp_note.size());
    check({tag, "_full"}, 32'(full), model_full);
  endtask

  task automatic do_play(input string tag);
    int total;
    total = play_total();
    @(negedge clk);
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    for (int t = 0; t <= total + 2; t++) begin
      if (t >= 2 && exp_at(t - 1) == exp_at(t) && exp_at(t) == exp_at(t + 1) &&
          ((t - 1 < total) == (t + 1 < total))) begin
        check({tag, "_note"}, 32'(note_out), exp_at(t));
        check({tag, "_en"}, 32'(play_en), (t < total) ? 1 : 0);
      end
      @(negedge clk);
    end
    check({tag, "_end_en"}, 32'(play_en), 0);
    check({tag, "_end_playing"}, 32'(playing), 0);
    check({tag, "_end_note"}, 32'(note_out), 0);
    check({tag, "_end_count"}, 32'(count), exp_note.size());
  endtask

  initial begin
    // ---- clock/reset ----
    rst_n      = 1'b0;
    note_in    = 4'd0;
    rec_start  = 1'b0;
    play_start = 1'b0;
    stop       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_note", 32'(note_out), 0);
    check("rst_en", 32'(play_en), 0);
    check("rst_rec", 32'(recording), 0);
    check("rst_play", 32'(playing), 0);
    check("rst_count", 32'(count), 0);
    check("rst_full", 32'(full), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---- play_start with empty buffer stays idle ----
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    repeat (3) @(negedge clk);
    check("empty_play_playing", 32'(playing), 0);
    check("empty_play_en", 32'(play_en), 0);

    // ---- stop + rec_start together in IDLE ----
    stop      = 1'b1;
    rec_start = 1'b1;
    note_in   = 4'd9;
    @(negedge clk);
    stop      = 1'b0;
    rec_start = 1'b0;
    repeat (2) @(negedge clk);
    check("stop_rec_idle", 32'(recording), 0);
    check("stop_rec_count", 32'(count), 0);

    // ---- run-length recording: 3 x3 ticks, 5 x2 ticks ----
    rec_seq = '{4'd3, 4'd3, 4'd3, 4'd5, 4'd5};
    do_record("rl");
    do_play("rl_play");

    // ---- stop mid-PLAY, then replay from entry 0 ----
    @(negedge clk);
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    repeat (15) @(negedge clk);
    check("mid_note", 32'(note_out), 3);
    check("mid_en", 32'(play_en), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_note", 32'(note_out), 0);
    check("stop_en", 32'(play_en), 0);
    check("stop_playing", 32'(playing), 0);
    check("stop_count", 32'(count), 2);
    do_play("replay");

    // ---- duration saturation: note 7 for 20 ticks ----
    rec_seq.delete();
    repeat (20) rec_seq.push_back(4'd7);
    do_record("sat");
    check("sat_dur0", 32'(exp_dur[0]), 15);
    do_play("sat_play");

    // ---- full buffer: 5 distinct notes, 1 tick each ----
    rec_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    do_record("full");
    do_play("full_play");

    // ---- randomized recordings ----
    for (int it = 0; it < 4; it++) begin
      int n;
      n = $urandom_range(3, 24);
      rec_seq.delete();
      for (int k = 0; k < n; k++) begin
        if (k > 0 && $urandom_range(0, 2) != 0) rec_seq.push_back(rec_seq[k - 1]);
        else rec_seq.push_back(4'($urandom_range(0, 15)));
      end
      do_record($sformatf("rnd%0d", it));
      do_play($sformatf("rnd%0d_play", it));
    end

    // ---- asynchronous reset mid-PLAY ----
    rec_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    do_record("prerst");
    @(negedge clk);
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    repeat (12) @(negedge clk);
    check("prerst_playing", 32'(playing), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_note", 32'(note_out), 0);
    check("arst_en", 32'(play_en), 0);
    check("arst_playing", 32'(playing), 0);
    check("arst_count", 32'(count), 0);
    check("arst_full", 32'(full), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
    repeat (3) @(negedge clk);
    check("postrst_play_ignored", 32'(playing), 0);

    // ---- report ----
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/note_recorder.md
Name: note_recorder

Overview:
- Record/playback engine for the piano's note path.
- In record mode it samples the 4-bit note code that the keyboard decoder feeds to the buzzer. It run-length encodes that code into an on-chip buffer of (note, duration) entries.
- In playback mode it regenerates the same 4-bit note stream and enable for the buzzer. It is the producer side of the note-code interface that the free-play path consumes.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- TICK_MS, 10, duration quantum in milliseconds. Cycles per tick = CLK_HZ/1000*TICK_MS.
- DEPTH, 64, number of buffer entries. Must be a power of two.
- DUR_W, 8, duration field width in ticks. Max run = 2^DUR_W-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- note_in  input  4  live note code from the keyboard decoder. 0 = silence, 1..15 = notes.
- rec_start  input  1  one-cycle pulse: begin recording.
- play_start  input  1  one-cycle pulse: begin playback.
- stop  input  1  one-cycle pulse: end the current operation.
- note_out  output  4  note code to the buzzer during playback; 0 otherwise.
- play_en  output  1  buzzer enable. High only while in PLAY.
- recording  output  1  high in REC.
- playing  output  1  high in PLAY.
- count  output  log2(DEPTH)+1  number of valid entries stored.
- full  output  1  high when count==DEPTH.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - note_out=0, play_en=0, recording=0, playing=0, count=0, full=0.
  - Tick counter, run registers and read index cleared.
  - Buffer contents are don't-care.
  - Reset mid-REC or mid-PLAY aborts immediately; recorded data is lost (count=0).
- Tick generator:
  - Free-running divider. Emits a one-cycle tick every CLK_HZ/1000*TICK_MS cycles.
  - Cleared to 0 on every entry to REC or PLAY, so the first tick arrives exactly one period after entry.
- Command priority, same cycle: stop > rec_start > play_start.
  - rec_start/play_start are ignored outside IDLE.
  - stop in IDLE has no effect.
- States: IDLE, REC, PLAY.
- IDLE -> REC on rec_start:
  - count=0.
  - cur_note=note_in sampled that cycle.
  - dur=0.
- REC, on each tick:
  - If note_in==cur_note and dur<MAX: dur+=1.
  - Otherwise: write {cur_note,dur} at index count if dur!=0, then count+=1. Then cur_note=note_in, dur=1.
  - Silence (0) is recorded as an ordinary run.
- REC exit paths:
  - On stop: flush the current run if dur!=0 and count<DEPTH, then go to IDLE the next cycle.
  - If a write makes count==DEPTH: go to IDLE the same cycle and assert full. The in-progress run is discarded.
- IDLE -> PLAY on play_start:
  - Only if count!=0; otherwise remain in IDLE.
  - idx=0, entry 0 loaded.
  - note_out and remaining=entry.dur are valid at most 2 cycles after play_start.
  - play_en=1.
- PLAY, on each tick:
  - remaining-=1.
  - When remaining reaches 0: idx+=1 and the next entry is loaded. note_out changes on the cycle following that tick (±1 cycle).
  - When idx==count: go to IDLE, note_out=0, play_en=0.
- PLAY on stop: go to IDLE next cycle, note_out=0, play_en=0. Buffer and count are preserved, so replay is possible.
- Buffer:
  - Single-write/single-read register array or inferred RAM. Synchronous write, read latency ≤1 cycle.
  - Contents persist across IDLE; they are overwritten only by a new REC.
- Outputs recording/playing/play_en/full are registered.

Test Plan (CLK_HZ=1000, TICK_MS=10 → 10 cycles/tick, DEPTH=4, DUR_W=4):
- Reset: assert rst_n=0 mid-PLAY -> next edge not required. Outputs 0 asynchronously, count=0, state IDLE.
- Record run-length: rec_start with note_in=3, hold 3 for 3 ticks, switch to 5 for 2 ticks, then stop -> count=2, entries {3,3},{5,2}. Check that the first run length includes the entry tick alignment.
- Duration saturation: record note 7 held for 20 ticks, then stop -> entries {7,15},{7,5}, count=2.
- Full: record 5 distinct notes, 1 tick each -> count=4, full=1, auto-return to IDLE after the 4th write. The 5th run is dropped.
- Playback: after the run-length recording above, play_start -> note_out=3 for 30±1 cycles, then 5 for 20±1 cycles, then 0. play_en is high throughout and drops with IDLE.
- Priority/empty: play_start with count=0 -> remains IDLE, play_en=0. Simultaneous stop+rec_start in IDLE -> stays IDLE. stop mid-PLAY -> note_out=0 next cycle, count unchanged, play_start replays from entry 0.
